// File: rtl/ram_port_ctrl_if.sv
// ============================================================================
// ram_port_ctrl_if : request, response and RAM-port signal bundle for ram_port_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

interface ram_port_ctrl_if #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [W_ADDR-1:0] req_addr;
  logic [W_DATA-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [W_DATA-1:0] rsp_rdata;

  logic              ram_we;
  logic [W_ADDR-1:0] ram_addr;
  logic [W_DATA-1:0] ram_din;
  logic [W_DATA-1:0] ram_dout;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
  );

  modport ram (
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

`default_nettype wire

// File: rtl/ram_port_ctrl.sv
// ============================================================================
// ram_port_ctrl : credit-based request/response front-end for a fixed-latency
//                 single-port RAM. Optional RAM_PORT_CTRL_STATS_EN adds counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_port_ctrl #(
  parameter int W_DATA    = 8,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = LATENCY + 1
) (
  input  logic           clk,
  input  logic           rstn,
  ram_port_ctrl_if.slave bus
`ifdef RAM_PORT_CTRL_STATS_EN
  ,
  output logic [31:0]    stat_reads,
  output logic [31:0]    stat_writes,
  output logic [31:0]    stat_stall_cycles
`endif
);

  localparam int W_ADDR = $clog2(DEPTH);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  localparam logic [CNT_W-1:0] C_RSP_DEPTH = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);

  logic              rd_acc;
  logic              wr_acc;
  logic              push;
  logic              pop;
  logic              rsp_valid_w;

  logic [CNT_W-1:0]  credits_q, credits_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [W_DATA-1:0] fifo_q [2**PTR_W];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + C_PTR_ONE;
  endfunction

  assign rsp_valid_w = (count_q != '0);
  assign pop         = rsp_valid_w & bus.rsp_ready;

  // A pop in this cycle frees a slot, so a read may use it immediately; this
  // is what sustains one read per cycle when RSP_DEPTH == LATENCY+1.
  assign bus.req_ready = rstn & (bus.req_we | (credits_q != '0) | pop);

  assign rd_acc = bus.req_valid & bus.req_ready & ~bus.req_we;
  assign wr_acc = bus.req_valid & bus.req_ready &  bus.req_we;

  assign bus.ram_we   = wr_acc;
  assign bus.ram_addr = W_ADDR'(bus.req_addr);
  assign bus.ram_din  = bus.req_wdata;

  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_rdata = rsp_valid_w ? fifo_q[rd_ptr_q] : '0;

  generate
    if (LATENCY == 0) begin : g_lat0
      assign push = rd_acc;
    end else begin : g_vpipe
      logic [LATENCY-1:0] vpipe_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vpipe_q <= '0;
        end else begin
          vpipe_q[0] <= rd_acc;
          for (int i = 1; i < LATENCY; i++) begin
            vpipe_q[i] <= vpipe_q[i-1];
          end
        end
      end

      assign push = vpipe_q[LATENCY-1];
    end
  endgenerate

  always_comb begin
    credits_d = credits_q;
    if (rd_acc && !pop) begin
      credits_d = credits_q - C_CNT_ONE;
    end else if (pop && !rd_acc) begin
      credits_d = credits_q + C_CNT_ONE;
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + C_CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - C_CNT_ONE;
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits_q <= C_RSP_DEPTH;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2**PTR_W; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= bus.ram_dout;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    push |-> ((count_q != C_RSP_DEPTH) || pop));

  a_no_credit_underflow: assert property (@(posedge clk) disable iff (!rstn)
    rd_acc |-> ((credits_q != '0) || pop));

`ifdef RAM_PORT_CTRL_STATS_EN
  logic [31:0] stat_reads_q;
  logic [31:0] stat_writes_q;
  logic [31:0] stat_stall_q;

  // All three counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (rd_acc && (stat_reads_q != '1)) begin
        stat_reads_q <= stat_reads_q + 32'd1;
      end
      if (wr_acc && (stat_writes_q != '1)) begin
        stat_writes_q <= stat_writes_q + 32'd1;
      end
      if (bus.req_valid && !bus.req_ready && (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_reads        = stat_reads_q;
  assign stat_writes       = stat_writes_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
// ============================================================================
// tb_ram_port_ctrl : directed bench for ram_port_ctrl at LATENCY 1, 0 and 3.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_port_ctrl;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  logic       s_valid;
  logic [7:0] s_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_port_ctrl_if #(.W_DATA(8), .W_ADDR(8)) bus  ();
  ram_port_ctrl_if #(.W_DATA(8), .W_ADDR(8)) bus0 ();
  ram_port_ctrl_if #(.W_DATA(8), .W_ADDR(8)) bus3 ();

`ifdef RAM_PORT_CTRL_STATS_EN
  logic [31:0] st_r,  st_w,  st_s;
  logic [31:0] st0_r, st0_w, st0_s;
  logic [31:0] st3_r, st3_w, st3_s;
`endif

  ram_port_ctrl #(.W_DATA(8), .DEPTH(256), .LATENCY(1), .RSP_DEPTH(2)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef RAM_PORT_CTRL_STATS_EN
    ,
    .stat_reads        (st_r),
    .stat_writes       (st_w),
    .stat_stall_cycles (st_s)
`endif
  );

  ram_port_ctrl #(.W_DATA(8), .DEPTH(256), .LATENCY(0), .RSP_DEPTH(1)) u_dut_l0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
`ifdef RAM_PORT_CTRL_STATS_EN
    ,
    .stat_reads        (st0_r),
    .stat_writes       (st0_w),
    .stat_stall_cycles (st0_s)
`endif
  );

  ram_port_ctrl #(.W_DATA(8), .DEPTH(256), .LATENCY(3), .RSP_DEPTH(4)) u_dut_l3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus3)
`ifdef RAM_PORT_CTRL_STATS_EN
    ,
    .stat_reads        (st3_r),
    .stat_writes       (st3_w),
    .stat_stall_cycles (st3_s)
`endif
  );

  // Main RAM model, one cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] mem_p1;
  always_ff @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    mem_p1 <= mem[bus.ram_addr];
  end
  assign bus.ram_dout = mem_p1;

  // Read-only preloaded RAM shared by the latency-0 and latency-3 instances.
  logic [7:0] mem_s [256];
  logic [7:0] p3_0, p3_1, p3_2;
  initial begin
    for (int i = 0; i < 256; i++) mem_s[i] = 8'(i * 7 + 1);
  end
  always_ff @(posedge clk) begin
    p3_0 <= mem_s[bus3.ram_addr];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign bus0.ram_dout = mem_s[bus0.ram_addr];
  assign bus3.ram_dout = p3_2;

  assign bus0.req_valid = s_valid;
  assign bus0.req_we    = 1'b0;
  assign bus0.req_addr  = s_addr;
  assign bus0.req_wdata = 8'h00;
  assign bus0.rsp_ready = 1'b1;
  assign bus3.req_valid = s_valid;
  assign bus3.req_we    = 1'b0;
  assign bus3.req_addr  = s_addr;
  assign bus3.req_wdata = 8'h00;
  assign bus3.rsp_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int iss;
    n_chk = 0;
    n_fail = 0;
    s_valid = 1'b0;
    s_addr = 8'h00;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    rstn = 1'b0;

    // Reset state: a write offered during reset is refused.
    step();
    drive(1'b1, 1'b1, 8'h01, 8'h11);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    rstn = 1'b1;
    step();

    // Write 0xA5 to 3, read it back the next cycle.
    bus.rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 8'd3, 8'hA5);
    #1;
    chk("wb_wr_ready", 32'(bus.req_ready), 32'd1);
    chk("wb_ram_we",   32'(bus.ram_we),    32'd1);
    step();
    drive(1'b1, 1'b0, 8'd3, 8'h00);
    #1;
    chk("wb_rd_ready", 32'(bus.req_ready), 32'd1);
    chk("wb_rd_we",    32'(bus.ram_we),    32'd0);
    chk("wb_rd_addr",  32'(bus.ram_addr),  32'd3);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("wb_rsp_early", 32'(bus.rsp_valid), 32'd0);
    step();
    #1;
    chk("wb_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wb_rsp_data",  32'(bus.rsp_rdata), 32'hA5);
    step();
    chk("wb_rsp_popped", 32'(bus.rsp_valid), 32'd0);

    // Streaming: fill 0..7 with addr*3, then read back-to-back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 8'(i), 8'(i * 3));
      #1;
      chk("st_wr_ready", 32'(bus.req_ready), 32'd1);
      step();
    end
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(1'b1, 1'b0, 8'(k), 8'h00);
      else       drive(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      if (k < 8) chk("st_rd_ready", 32'(bus.req_ready), 32'd1);
      chk("st_rsp_valid", 32'(bus.rsp_valid), 32'((k >= 2) && (k < 10)));
      if ((k >= 2) && (k < 10)) chk("st_rsp_data", 32'(bus.rsp_rdata), 32'((k - 2) * 3));
      step();
    end

    // Back-pressure with two credits.
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'd0, 8'h00);
    #1;
    chk("bp_rd0_ready", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 8'd1, 8'h00);
    #1;
    chk("bp_rd1_ready", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 8'd2, 8'h00);
    #1;
    chk("bp_rd2_stall", 32'(bus.req_ready), 32'd0);
    step();
    #1;
    chk("bp_rd2_stall2", 32'(bus.req_ready), 32'd0);
    chk("bp_head_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_head_data",  32'(bus.rsp_rdata), 32'd0);
    step();
    drive(1'b1, 1'b1, 8'd10, 8'h77);
    #1;
    chk("bp_wr_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_wr_ram_we", 32'(bus.ram_we),   32'd1);
    step();
    bus.rsp_ready = 1'b1;
    got = 0;
    iss = 2;
    for (int c = 0; c < 20 && got < 4; c++) begin
      drive(1'(iss < 4), 1'b0, 8'(iss), 8'h00);
      #1;
      if (bus.rsp_valid) begin
        chk("bp_order", 32'(bus.rsp_rdata), 32'(got * 3));
        got++;
      end
      if ((iss < 4) && bus.req_ready) iss++;
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("bp_rsp_count", 32'(got), 32'd4);
    chk("bp_issued",    32'(iss), 32'd4);

    // Reset with two reads in flight; credits must come back.
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 8'd4, 8'h00);
    step();
    drive(1'b1, 1'b0, 8'd5, 8'h00);
    step();
    drive(1'b1, 1'b1, 8'd0, 8'h00);
    rstn = 1'b0;
    #1;
    chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mr_ram_we",    32'(bus.ram_we),    32'd0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("mr_quiet", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    drive(1'b1, 1'b0, 8'd6, 8'h00);
    #1;
    chk("mr_cred0", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 8'd7, 8'h00);
    #1;
    chk("mr_cred1", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b1, 1'b0, 8'd0, 8'h00);
    #1;
    chk("mr_cred_out", 32'(bus.req_ready), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    bus.rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) begin
        chk("mr_data", 32'(bus.rsp_rdata), 32'((6 + got) * 3));
        got++;
      end
      step();
    end
    chk("mr_rsp_count", 32'(got), 32'd2);

    // Fresh reset before the latency and statistics checks.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();

    // LATENCY 0 and 3: one read of preloaded address 9 (0x40).
    s_valid = 1'b1;
    s_addr  = 8'd9;
    #1;
    chk("l0_ready", 32'(bus0.req_ready), 32'd1);
    chk("l3_ready", 32'(bus3.req_ready), 32'd1);
    step();
    s_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("l0_valid", 32'(bus0.rsp_valid), 32'(k == 1));
      chk("l3_valid", 32'(bus3.rsp_valid), 32'(k == 4));
      if (k == 1) chk("l0_data", 32'(bus0.rsp_rdata), 32'h40);
      if (k == 4) chk("l3_data", 32'(bus3.rsp_rdata), 32'h40);
      step();
    end

    // 5 writes, 3 reads, 4 stall cycles on the main instance.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'(20 + i), 8'(i));
      #1;
      chk("sx_wr_ready", 32'(bus.req_ready), 32'd1);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 8'(20 + i), 8'h00);
      #1;
      chk("sx_rd_ready", 32'(bus.req_ready), 32'd1);
      step();
    end
    drive(1'b1, 1'b0, 8'd22, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sx_stall", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("sx_release", 32'(bus.req_ready), 32'd1);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
`ifdef RAM_PORT_CTRL_STATS_EN
    chk("stat_writes",       st_w,  32'd5);
    chk("stat_reads",        st_r,  32'd3);
    chk("stat_stall_cycles", st_s,  32'd4);
    chk("l0_stat_reads",     st0_r, 32'd1);
    chk("l0_stat_writes",    st0_w, 32'd0);
    chk("l0_stat_stalls",    st0_s, 32'd0);
    chk("l3_stat_reads",     st3_r, 32'd1);
    chk("l3_stat_writes",    st3_w, 32'd0);
    chk("l3_stat_stalls",    st3_s, 32'd0);
`endif
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
